alu_rr_sched: RTL
=================

# alu_rr_sched

Round-robin scheduler that shares one `ALU_4_bit` instance between `N_REQ` requesters. Each requester presents an opcode and two signed 4-bit operands with a valid/ready handshake. The scheduler grants one request at a time, sequences it through the registered ALU, and returns the 5-bit signed result tagged with the requester index on a single response channel. It sits between the per-lane operand sources and the shared ALU datapath.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.

Ports:
- `clk`  input  1  clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `req_valid`  input  N_REQ  per-requester request valid.
- `req_ready`  output  N_REQ  per-requester accept; at most one bit high (one-hot or zero).
- `req_opcode`  input  2*N_REQ  packed opcodes (`opcode_e`), lane i at [2i+1:2i].
- `req_A`  input  4*N_REQ  packed signed operands A, lane i at [4i+3:4i].
- `req_B`  input  4*N_REQ  packed signed operands B, same packing.
- `rsp_valid`  output  1  response valid.
- `rsp_ready`  input  1  response consumer ready.
- `rsp_id`  output  ID_W  index of the requester the response belongs to.
- `rsp_C`  output  5  signed ALU result.
- `busy`  output  1  high whenever state is not IDLE.
- `ops_done`  output  8  count of completed responses (handshakes), wraps 255→0.

## Operation
- FSM states (`sched_state_e`): IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, choose the first set bit searching upward from `rr_ptr`, modulo N_REQ. Drive `req_ready[g]`=1 combinationally in the same cycle. At the clock edge, latch the opcode, A and B into the issue registers, latch g into `rsp_id`, and go to EXEC. If no `req_valid`, stay in IDLE.
- EXEC: the issue registers drive the ALU. The ALU registers C at the end of this cycle. Go to RESP.
- RESP: `rsp_valid`=1 and `rsp_C` = ALU C. The issue registers hold, so C is stable. On `rsp_valid && rsp_ready`:
  - increment `ops_done`;
  - set `rr_ptr` ← (`rsp_id`+1) mod N_REQ;
  - go to IDLE.
- Without `rsp_ready`, stay in RESP and hold all outputs stable.
- `req_ready` is all-zero outside IDLE. A requester must hold its valid and data until it is accepted.
- The ALU's active-high `reset` is driven by `~reset`. No other ALU reset source exists.
- Result arithmetic is defined by the ALU, with 4-bit signed operands extended to 5 bits:
  - Add: A+B.
  - Sub: A−B.
  - Not_A: ~A, computed on the 5-bit sign-extended value.
  - ReductionOR_B: |B, zero-extended.

## Timing
- Reset values, while `reset`=0 and in the cycle after it is released:
  - state IDLE; `rr_ptr`=0;
  - `req_ready`=0 while `reset`=0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_C`=0, `busy`=0, `ops_done`=0.
- Latency: request accepted at the edge ending cycle k → `rsp_valid` high in cycle k+2.
- Throughput: one operation per 3 cycles at most (IDLE, EXEC, RESP). The next acceptance can be in the cycle after the response handshake, not the same cycle.
- Simultaneous valids are resolved only by `rr_ptr`. A lane that has just been served has the lowest priority for the next grant.
- A valid that rises while the scheduler is busy waits and is never dropped.
- Reset asserted mid-operation (in EXEC or RESP) abandons the in-flight operation. There is no response for it and `ops_done` is not incremented.
- `ops_done` wraps from 255 to 0 with no flag.

## Structure
- Add to `pack_file`:
  - `sched_state_e` (IDLE, EXEC, RESP);
  - a `sched_req_t` struct (`opcode_e` opcode, signed [3:0] A, B).
- Reuse the existing `opcode_e` from `pack_file`.
- One sub-module: an instance of `ALU_4_bit`. The round-robin pick is a function inside `alu_rr_sched`, not a separate module.

## Test plan
- Reset then lane 0 Add A=3, B=4: `req_ready[0]` high in the accept cycle, `rsp_valid` 2 cycles later with `rsp_C`=7, `rsp_id`=0, `ops_done`=1.
- All 4 lanes valid continuously, `rsp_ready`=1: grant order 0,1,2,3,0,1 and one response every 3 cycles.
- Lane 2 Sub A=−8, B=7 with `rsp_ready` low for 5 cycles: `rsp_C`=−15 held stable for 6 cycles, `req_ready`=0 throughout, and lane 1 (valid meanwhile) is granted next.
- Lane 1 Not_A A=5 → `rsp_C`=−6; lane 3 ReductionOR_B B=0 → 0 and B=−1 → 1.
- `reset` driven low during EXEC: the next cycle shows `rsp_valid`=0, `busy`=0, `ops_done` unchanged, and the next grant starts from lane 0.
- 256 completed operations: `ops_done` reads 0 after the last handshake.

Source files
------------

// File: rtl/pack_file.sv
// Shared types for the ALU datapath and its round-robin front end.
// Latency: n/a (types only).
// Backpressure: n/a.
package pack_file;

    typedef enum logic [1:0] {
        Add           = 2'b00,
        Sub           = 2'b01,
        Not_A         = 2'b10,
        ReductionOR_B = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } sched_state_e;

    typedef struct packed {
        opcode_e            opcode;
        logic signed [3:0]  A;
        logic signed [3:0]  B;
    } sched_req_t;

endpackage

// File: rtl/ALU_4_bit.sv
// Registered 4-bit signed ALU producing a 5-bit signed result.
// Latency: 1 cycle, C updates every clock from the current inputs.
// Backpressure: none; caller holds inputs to keep C stable.
module ALU_4_bit
    import pack_file::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        opcode,
    input  logic signed [3:0] A,
    input  logic signed [3:0] B,
    output logic signed [4:0] C
);

    logic signed [4:0] a_ext;
    logic signed [4:0] b_ext;

    assign a_ext = {A[3], A};
    assign b_ext = {B[3], B};

    always_ff @(posedge clk) begin
        if (reset) begin
            C <= '0;
        end else begin
            case (opcode_e'(opcode))
                Add:           C <= a_ext + b_ext;
                Sub:           C <= a_ext - b_ext;
                Not_A:         C <= ~a_ext;
                ReductionOR_B: C <= {4'b0000, |B};
                default:       C <= '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin arbiter sharing one registered ALU among N_REQ requesters.
// Latency: accept at edge ending cycle k, rsp_valid in cycle k+2; 3 cycles per op minimum.
// Backpressure: req_ready only in IDLE; RESP holds all outputs until rsp_ready.
module alu_rr_sched
    import pack_file::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_opcode,
    input  logic [4*N_REQ-1:0]   req_A,
    input  logic [4*N_REQ-1:0]   req_B,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [4:0]           rsp_C,
    output logic                 busy,
    output logic [7:0]           ops_done
);

    // Descending scan so the last hit, i.e. the nearest lane at/after ptr, wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                                input logic [ID_W-1:0]  ptr);
        int idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (vld[idx]) rr_pick = ID_W'(idx);
        end
    endfunction

    sched_state_e      state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              any_vld;
    sched_req_t        lane_req;
    sched_req_t        issue;
    logic signed [4:0] alu_c;

    assign any_vld   = |req_valid;
    assign grant_idx = rr_pick(req_valid, rr_ptr);

    always_comb begin
        int gi;
        gi              = int'(grant_idx);
        lane_req.opcode = opcode_e'(req_opcode[2*gi +: 2]);
        lane_req.A      = req_A[4*gi +: 4];
        lane_req.B      = req_B[4*gi +: 4];
    end

    always_comb begin
        req_ready = '0;
        if (reset && state == IDLE && any_vld) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_id    <= '0;
            issue     <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        issue  <= lane_req;
                        rsp_id <= grant_idx;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue registers hold through RESP, so the ALU keeps re-registering the same C.
    ALU_4_bit u_alu (
        .clk    (clk),
        .reset  (~reset),
        .opcode (issue.opcode),
        .A      (issue.A),
        .B      (issue.B),
        .C      (alu_c)
    );

    assign rsp_C = alu_c;

endmodule
